// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display scan controller.
//   - SEG_* : segment codes {g,f,e,d,c,b,a}, active-high, before polarity
//   - upd_state_t : update FSM state encoding
//   - slot_onehot : digit slot index to an-bit mask (bit0 = units)
package disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } upd_state_t;

  function automatic logic [2:0] slot_onehot(input logic [1:0] slot);
    case (slot)
      2'd0:    slot_onehot = 3'b001;
      2'd1:    slot_onehot = 3'b010;
      default: slot_onehot = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to 7-segment decoder.
//   nibble : input  [3:0] BCD digit
//   code   : output [6:0] active-high segments {g,f,e,d,c,b,a};
//            non-decimal nibbles (10..15) show a dash
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  always_comb begin
    code = SEG_DASH;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: periodically requests a BCD conversion and multiplexes the
// three resulting digits onto a common-segment 7-segment display.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bcd_in    : {hundreds, tens, units} BCD from the converter
//   bcd_valid : one-cycle pulse, bcd_in valid
//   conv_req  : one-cycle conversion request to the converter
//   seg       : segments {g,f,e,d,c,b,a}
//   an        : digit enables, bit0 = units, bit2 = hundreds
//   stale     : last request timed out; hundreds shows a dash
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros in
// the hundreds and tens positions.
//
// Update FSM states:
//   state | meaning
//   IDLE  | counting UPDATE_DIV cycles until the next request
//   REQ   | conv_req asserted for this single cycle
//   WAIT  | waiting for bcd_valid, bounded by TIMEOUT cycles from the request
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int UPDATE_DIV     = 5000000,
  parameter int TIMEOUT        = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  output logic        conv_req,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        stale
);

  localparam int UPD_W  = $clog2(UPDATE_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPDATE_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  // ---------------- update FSM ----------------
  upd_state_t        state, state_nxt;
  logic [UPD_W-1:0]  upd_cnt, upd_cnt_nxt;
  logic [TO_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic              stale_q, stale_nxt;
  logic [11:0]       disp_reg, disp_nxt;
  logic              conv_req_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      upd_cnt  <= '0;
      wait_cnt <= '0;
      stale_q  <= 1'b0;
      disp_reg <= '0;
    end else begin
      state    <= state_nxt;
      upd_cnt  <= upd_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      stale_q  <= stale_nxt;
      disp_reg <= disp_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    upd_cnt_nxt  = upd_cnt;
    wait_cnt_nxt = wait_cnt;
    stale_nxt    = stale_q;
    disp_nxt     = disp_reg;
    conv_req_c   = 1'b0;

    // A reply is accepted in any state; only a reply inside WAIT ends the
    // request and clears stale.
    if (bcd_valid) disp_nxt = bcd_in;

    case (state)
      IDLE: begin
        if (upd_cnt == UPD_LAST) begin
          upd_cnt_nxt = '0;
          state_nxt   = REQ;
        end else begin
          upd_cnt_nxt = upd_cnt + 1'b1;
        end
      end
      REQ: begin
        conv_req_c   = 1'b1;
        // The request cycle itself counts toward the timeout window.
        wait_cnt_nxt = TO_W'(1);
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (bcd_valid) begin
          stale_nxt    = 1'b0;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else if (wait_cnt == TO_LAST) begin
          stale_nxt    = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        upd_cnt_nxt  = '0;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------- scan multiplexer ----------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        slot;
  logic [2:0]        an_q;
  logic [6:0]        seg_q;
  logic [3:0]        nib;
  logic [6:0]        dec_code;
  logic [6:0]        slot_code;
  logic              blank_lead;

  always_comb begin
    case (slot)
      2'd0:    nib = disp_reg[3:0];
      2'd1:    nib = disp_reg[7:4];
      default: nib = disp_reg[11:8];
    endcase
  end

  seg7_decode u_dec (
    .nibble (nib),
    .code   (dec_code)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic hund_blank;
  // Tens is only blanked when hundreds is actually blanked, so a stale dash
  // in front never leaves a gap.
  assign hund_blank = (disp_reg[11:8] == 4'd0) && !stale_q;
  assign blank_lead = ((slot == 2'd2) && hund_blank) ||
                      ((slot == 2'd1) && hund_blank && (disp_reg[7:4] == 4'd0));
`else
  assign blank_lead = 1'b0;
`endif

  always_comb begin
    slot_code = dec_code;
    if ((slot == 2'd2) && stale_q) slot_code = SEG_DASH;
    else if (blank_lead)           slot_code = SEG_BLANK;
  end

  // seg is latched once per slot, during the dead cycle, so a capture in the
  // middle of a slot only shows from the next slot onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      slot     <= 2'd0;
      an_q     <= 3'b000;
      seg_q    <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        slot     <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        an_q     <= 3'b000;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
        an_q     <= slot_onehot(slot);
      end
      if (scan_cnt == '0) seg_q <= slot_code;
    end
  end

  assign conv_req = conv_req_c;
  assign stale    = stale_q;
  assign seg      = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign an       = SEG_ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl with SCAN_DIV=4,
// UPDATE_DIV=64, TIMEOUT=16 and active-low outputs. Expectations follow
// LEADING_ZERO_BLANK_EN when it is defined.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd_in = 12'h000;
  logic        bcd_valid = 1'b0;
  logic        conv_req;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        stale;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;      // cycles since last reset release
  int cap = 0;    // cycle count at the most recent capture / timeout edge
  int c_req = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] EXP_H0 = SEG_BLANK;
  localparam logic [6:0] EXP_T0 = SEG_BLANK;
`else
  localparam logic [6:0] EXP_H0 = SEG_0;
  localparam logic [6:0] EXP_T0 = SEG_0;
`endif

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .SCAN_DIV       (4),
    .UPDATE_DIV     (64),
    .TIMEOUT        (16),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .conv_req  (conv_req),
    .seg       (seg),
    .an        (an),
    .stale     (stale)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic tick_to(input int target);
    while (n < target) tick();
  endtask

  task automatic wait_conv(input string name, input int exp_cyc);
    int c;
    c = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (conv_req === 1'b1) begin
        c = n;
        break;
      end
    end
    c_req = n;
    vectors++;
    if (c !== exp_cyc) begin
      miscompares++;
      $display("FAIL %s: conv_req at cycle %0d, expected cycle %0d", name, c, exp_cyc);
    end
  endtask

  task automatic send_reply(input logic [11:0] v, input int at_cyc);
    tick_to(at_cyc);
    bcd_in    = v;
    bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    cap = n;
  endtask

  task automatic check_stale(input string name, input logic exp_s);
    vectors++;
    if (stale !== exp_s) begin
      miscompares++;
      $display("FAIL %s: stale=%b, expected %b (cycle %0d)", name, stale, exp_s, n);
    end
  endtask

  // Walks to the first active cycle of the units slot, then checks each slot
  // and the following dead cycle.
  task automatic check_digits(input string name, input logic [6:0] eh,
                              input logic [6:0] et, input logic [6:0] eu);
    int start;
    int guard;
    start = n;
    guard = 0;
    tick();
    while (!(((n % 12) == 1) && (n >= start + 2)) && (guard < 30)) begin
      tick();
      guard++;
    end
    vectors++;
    if (an !== 3'b110 || seg !== ~eu) begin
      miscompares++;
      $display("FAIL %s units: an=%b seg=%b, expected an=110 seg=%b", name, an, seg, ~eu);
    end
    repeat (4) tick();
    vectors++;
    if (an !== 3'b101 || seg !== ~et) begin
      miscompares++;
      $display("FAIL %s tens: an=%b seg=%b, expected an=101 seg=%b", name, an, seg, ~et);
    end
    repeat (4) tick();
    vectors++;
    if (an !== 3'b011 || seg !== ~eh) begin
      miscompares++;
      $display("FAIL %s hundreds: an=%b seg=%b, expected an=011 seg=%b", name, an, seg, ~eh);
    end
    repeat (3) tick();
    vectors++;
    if (an !== 3'b111) begin
      miscompares++;
      $display("FAIL %s dead: an=%b, expected 111", name, an);
    end
  endtask

  task automatic test_reset();
    logic early;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({conv_req, an, seg, stale} !== {1'b0, 3'b111, 7'h7F, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold: req/an/seg/stale=%b/%b/%b/%b, expected 0/111/1111111/0",
               conv_req, an, seg, stale);
    end
    rst = 1'b0;
    n = 0;
    vectors++;
    if ({conv_req, an, seg} !== {1'b0, 3'b111, 7'h7F}) begin
      miscompares++;
      $display("FAIL reset_release: req/an/seg=%b/%b/%b, expected 0/111/1111111",
               conv_req, an, seg);
    end
    early = 1'b0;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (conv_req !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL early_req: conv_req seen before cycle 64 (flag=%b), expected none", early);
    end
    tick();
    vectors++;
    if (conv_req !== 1'b1) begin
      miscompares++;
      $display("FAIL first_req: conv_req=%b at cycle %0d, expected 1", conv_req, n);
    end
    c_req = n;
  endtask

  task automatic test_valid_reply();
    tick();
    vectors++;
    if (conv_req !== 1'b0) begin
      miscompares++;
      $display("FAIL req_pulse: conv_req=%b one cycle after request, expected 0", conv_req);
    end
    send_reply(12'h255, c_req + 12);
    check_stale("reply_stale", 1'b0);
    check_digits("show_255", SEG_2, SEG_5, SEG_5);
  endtask

  task automatic test_timeout();
    wait_conv("timeout_req", cap + 64);
    tick_to(c_req + 15);
    check_stale("pre_timeout", 1'b0);
    tick();
    check_stale("timeout", 1'b1);
    cap = n;
    check_digits("stale_dash", SEG_DASH, SEG_5, SEG_5);
    wait_conv("recover_req", cap + 64);
    send_reply(12'h100, c_req + 12);
    check_stale("recover_stale", 1'b0);
    check_digits("show_100", SEG_1, SEG_0, SEG_0);
  endtask

  task automatic test_bad_digit();
    wait_conv("bad_digit_req", cap + 64);
    // Reply lands on the timeout edge: capture wins, stale stays clear.
    send_reply(12'h0A7, c_req + 15);
    check_stale("valid_at_timeout", 1'b0);
    check_digits("show_0A7", EXP_H0, SEG_DASH, SEG_7);
  endtask

  task automatic test_leading_zero();
    wait_conv("lz_req", cap + 64);
    send_reply(12'h007, c_req + 12);
    check_digits("show_007", EXP_H0, EXP_T0, SEG_7);
  endtask

  task automatic test_reset_in_wait();
    wait_conv("rst_wait_req", cap + 64);
    tick_to(c_req + 5);
    rst       = 1'b1;
    bcd_in    = 12'h123;
    bcd_valid = 1'b1;
    tick();
    rst       = 1'b0;
    bcd_valid = 1'b0;
    n = 0;
    vectors++;
    if ({conv_req, an, seg, stale} !== {1'b0, 3'b111, 7'h7F, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_in_wait: req/an/seg/stale=%b/%b/%b/%b, expected 0/111/1111111/0",
               conv_req, an, seg, stale);
    end
    check_digits("after_rst", EXP_H0, EXP_T0, SEG_0);
    wait_conv("post_rst_req", 64);
  endtask

  initial begin
    test_reset();
    test_valid_reply();
    test_timeout();
    test_bad_digit();
    test_leading_zero();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
